// File: rtl/mips_id_stage_pkg.sv
// Shared definitions for the MIPS decode stage: opcode constants, FSM states and tie-off levels.
// VCC/GND and the opcode names are the stage's common vocabulary for the decoder and the top.
package mips_id_stage_pkg;

    localparam logic VCC = 1'b1;
    localparam logic GND = 1'b0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_VALID = 2'd2
    } idState_e;

    // Logical immediates are unsigned; every other I-type immediate is signed.
    function automatic logic isZeroExt(input logic [5:0] opcode);
        return (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
    endfunction

endpackage

// File: rtl/mips_id_stage_if.sv
// Fetch, register-file, write-back and execute signals of the decode stage.
// The stage uses the slave view; its environment (fetch/RAM/execute or a bench) uses master.
interface mips_id_stage_if;

    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  rf_ra;
    logic [4:0]  rf_rb;
    logic [31:0] rf_douta;
    logic [31:0] rf_doutb;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        id_flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [5:0]  ex_opcode;
    logic [5:0]  ex_funct;
    logic [4:0]  ex_shamt;
    logic [4:0]  ex_rd;
    logic [31:0] ex_imm;
    logic [31:0] ex_a;
    logic [31:0] ex_b;

    modport slave (
        input  if_valid, if_instr, if_pc, rf_douta, rf_doutb,
               wb_we, wb_addr, wb_data, id_flush, ex_ready,
        output if_ready, rf_ra, rf_rb, ex_valid, ex_pc, ex_opcode,
               ex_funct, ex_shamt, ex_rd, ex_imm, ex_a, ex_b
    );

    modport master (
        output if_valid, if_instr, if_pc, rf_douta, rf_doutb,
               wb_we, wb_addr, wb_data, id_flush, ex_ready,
        input  if_ready, rf_ra, rf_rb, ex_valid, ex_pc, ex_opcode,
               ex_funct, ex_shamt, ex_rd, ex_imm, ex_a, ex_b
    );

endinterface

// File: rtl/mips_id_stage_imm_ext.sv
// id_imm_ext: combinational immediate extender and destination-register selector.
module id_imm_ext
    import mips_id_stage_pkg::*;
(
    input  logic [5:0]  opcode_i,
    input  logic [15:0] imm16_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rdField_i,
    output logic [31:0] imm_o,
    output logic [4:0]  rd_o
);

    always_comb begin
        imm_o = {{16{imm16_i[15]}}, imm16_i};
        if (isZeroExt(opcode_i)) begin
            imm_o = {16'h0000, imm16_i};
        end else if (opcode_i == OP_LUI) begin
            imm_o = {imm16_i, 16'h0000};
        end
    end

    // R-type writes rd, jal links into $ra, I-type writes rt.
    always_comb begin
        rd_o = rt_i;
        if (opcode_i == OP_RTYPE) begin
            rd_o = rdField_i;
        end else if (opcode_i == OP_JAL) begin
            rd_o = REG_RA;
        end
    end

endmodule

// File: rtl/mips_id_stage.sv
// Decode stage: accepts an instruction, reads rs/rt from the block-RAM register file, presents a registered bundle.
// Define ID_BYPASS_EN to forward write-back values into the operands (accept cycle, read cycle and while held).
module mips_id_stage
    import mips_id_stage_pkg::*;
(
    input  logic            sys_clk,
    input  logic            sys_rst_n,
    mips_id_stage_if.slave  bus
);

    idState_e    state_q, state_d;
    logic [31:0] instr_q, pc_q;
    logic [31:0] exPc_q, exImm_q, exA_q, exB_q;
    logic [5:0]  exOpcode_q, exFunct_q;
    logic [4:0]  exShamt_q, exRd_q;
    logic        ifReady, accept;
    logic [4:0]  rs, rt, acceptRs, acceptRt;
    logic [31:0] decImm, opA, opB;
    logic [4:0]  decRd;

    assign rs       = instr_q[25:21];
    assign rt       = instr_q[20:16];
    assign acceptRs = bus.if_instr[25:21];
    assign acceptRt = bus.if_instr[20:16];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.id_flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept) state_d = S_READ;
                S_READ:  state_d = S_VALID;
                S_VALID: if (bus.ex_ready) state_d = accept ? S_READ : S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Read addresses come straight from fetch on accept so the RAM data lands in S_READ.
    always_comb begin
        ifReady      = sys_rst_n && !bus.id_flush &&
                       ((state_q == S_IDLE) || ((state_q == S_VALID) && bus.ex_ready));
        accept       = bus.if_valid && ifReady;
        bus.if_ready = ifReady;
        bus.ex_valid = (state_q == S_VALID);
        bus.rf_ra    = accept ? acceptRs : rs;
        bus.rf_rb    = accept ? acceptRt : rt;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            instr_q <= '0;
            pc_q    <= '0;
        end else if (accept) begin
            instr_q <= bus.if_instr;
            pc_q    <= bus.if_pc;
        end
    end

    id_imm_ext u_imm_ext (
        .opcode_i  (instr_q[31:26]),
        .imm16_i   (instr_q[15:0]),
        .rt_i      (rt),
        .rdField_i (instr_q[15:11]),
        .imm_o     (decImm),
        .rd_o      (decRd)
    );

`ifdef ID_BYPASS_EN
    logic        fwdAValid_q, fwdBValid_q;
    logic [31:0] fwdAData_q, fwdBData_q;

    // The RAM is read-first, so a write committed in the accept cycle must be remembered here.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fwdAValid_q <= GND;
            fwdBValid_q <= GND;
            fwdAData_q  <= '0;
            fwdBData_q  <= '0;
        end else if (accept) begin
            fwdAValid_q <= bus.wb_we && (bus.wb_addr == acceptRs);
            fwdBValid_q <= bus.wb_we && (bus.wb_addr == acceptRt);
            fwdAData_q  <= bus.wb_data;
            fwdBData_q  <= bus.wb_data;
        end
    end

    always_comb begin
        opA = bus.rf_douta;
        opB = bus.rf_doutb;
        if (bus.wb_we && (bus.wb_addr == rs)) begin
            opA = bus.wb_data;
        end else if (fwdAValid_q) begin
            opA = fwdAData_q;
        end
        if (bus.wb_we && (bus.wb_addr == rt)) begin
            opB = bus.wb_data;
        end else if (fwdBValid_q) begin
            opB = fwdBData_q;
        end
        if (rs == REG_ZERO) opA = '0;
        if (rt == REG_ZERO) opB = '0;
    end
`else
    logic unusedWb;
    assign unusedWb = ^{bus.wb_we, bus.wb_addr, bus.wb_data};

    always_comb begin
        opA = (rs == REG_ZERO) ? '0 : bus.rf_douta;
        opB = (rt == REG_ZERO) ? '0 : bus.rf_doutb;
    end
`endif

    // The bundle is built in S_READ; with bypass a held bundle still tracks write-backs to its sources.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            exPc_q     <= '0;
            exOpcode_q <= '0;
            exFunct_q  <= '0;
            exShamt_q  <= '0;
            exRd_q     <= '0;
            exImm_q    <= '0;
            exA_q      <= '0;
            exB_q      <= '0;
        end else if (state_q == S_READ) begin
            exPc_q     <= pc_q;
            exOpcode_q <= instr_q[31:26];
            exFunct_q  <= instr_q[5:0];
            exShamt_q  <= instr_q[10:6];
            exRd_q     <= decRd;
            exImm_q    <= decImm;
            exA_q      <= opA;
            exB_q      <= opB;
`ifdef ID_BYPASS_EN
        end else if (state_q == S_VALID && bus.wb_we) begin
            if (rs != REG_ZERO && bus.wb_addr == rs) exA_q <= bus.wb_data;
            if (rt != REG_ZERO && bus.wb_addr == rt) exB_q <= bus.wb_data;
`endif
        end
    end

    assign bus.ex_pc     = exPc_q;
    assign bus.ex_opcode = exOpcode_q;
    assign bus.ex_funct  = exFunct_q;
    assign bus.ex_shamt  = exShamt_q;
    assign bus.ex_rd     = exRd_q;
    assign bus.ex_imm    = exImm_q;
    assign bus.ex_a      = exA_q;
    assign bus.ex_b      = exB_q;

endmodule

// File: tb/tb_mips_id_stage.sv
// Scoreboard bench for mips_id_stage: a read-first register-file RAM, directed cases and random traffic.
// Compile with ID_BYPASS_EN defined to expect forwarded operands.
module tb_mips_id_stage;

    typedef struct {
        logic [31:0] pc;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] imm;
        logic [31:0] a;
        logic [31:0] b;
    } bundle_t;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [31:0] regFile [32];
    bundle_t     expQ [$];
    int          checks;
    int          failures;
    bit          busy;
    int          age;
    logic [4:0]  lastRs, lastRt;
    logic [5:0]  opList [10];

    mips_id_stage_if bus();

    mips_id_stage dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Dual-port block RAM with one-cycle synchronous, read-first reads; written by write-back.
    always @(posedge sys_clk) begin
        bus.rf_douta <= regFile[bus.rf_ra];
        bus.rf_doutb <= regFile[bus.rf_rb];
        if (bus.wb_we) regFile[bus.wb_addr] <= bus.wb_data;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Reference decode straight from the instruction-set rules; operands are the architectural register values.
    function automatic bundle_t predict(input logic [31:0] instr, input logic [31:0] pc);
        bundle_t     e;
        logic [31:0] imm16;
        int          op;
        op       = int'(instr[31:26]);
        imm16    = {16'h0000, instr[15:0]};
        e.pc     = pc;
        e.opcode = instr[31:26];
        e.funct  = instr[5:0];
        e.shamt  = instr[10:6];
        e.rs     = instr[25:21];
        e.rt     = instr[20:16];
        case (op)
            12, 13, 14: e.imm = imm16;
            15:         e.imm = imm16 * 32'd65536;
            default:    e.imm = (imm16 >= 32'd32768) ? imm16 + 32'hFFFF0000 : imm16;
        endcase
        if (op == 0)      e.rd = instr[15:11];
        else if (op == 3) e.rd = 5'd31;
        else              e.rd = instr[20:16];
        e.a = (e.rs == 5'd0) ? 32'd0 : regFile[e.rs];
        e.b = (e.rt == 5'd0) ? 32'd0 : regFile[e.rt];
        return e;
    endfunction

    // Monitor: predicts handshakes from occupancy and age, compares the presented bundle with the queue head.
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            busy   = 1'b0;
            age    = 0;
            lastRs = 5'd0;
            lastRt = 5'd0;
            expQ.delete();
        end else begin
            bit          expValid;
            bit          expReady;
            bundle_t     e;
            logic [31:0] ea;
            logic [31:0] eb;
            expValid = busy && (age >= 2);
            expReady = !bus.id_flush && (!busy || (expValid && bus.ex_ready));
            checkOutput("if_ready", 32'(bus.if_ready), 32'(expReady));
            checkOutput("ex_valid", 32'(bus.ex_valid), 32'(expValid));
            if (bus.if_valid && expReady) begin
                checkOutput("rf_ra accept", 32'(bus.rf_ra), 32'(bus.if_instr[25:21]));
                checkOutput("rf_rb accept", 32'(bus.rf_rb), 32'(bus.if_instr[20:16]));
            end else begin
                checkOutput("rf_ra held", 32'(bus.rf_ra), 32'(lastRs));
                checkOutput("rf_rb held", 32'(bus.rf_rb), 32'(lastRt));
            end
            if (expValid && expQ.size() > 0) begin
                e = expQ[0];
`ifdef ID_BYPASS_EN
                ea = (e.rs == 5'd0) ? 32'd0 : regFile[e.rs];
                eb = (e.rt == 5'd0) ? 32'd0 : regFile[e.rt];
`else
                ea = e.a;
                eb = e.b;
`endif
                checkOutput("ex_pc", bus.ex_pc, e.pc);
                checkOutput("ex_opcode", 32'(bus.ex_opcode), 32'(e.opcode));
                checkOutput("ex_funct", 32'(bus.ex_funct), 32'(e.funct));
                checkOutput("ex_shamt", 32'(bus.ex_shamt), 32'(e.shamt));
                checkOutput("ex_rd", 32'(bus.ex_rd), 32'(e.rd));
                checkOutput("ex_imm", bus.ex_imm, e.imm);
                checkOutput("ex_a", bus.ex_a, ea);
                checkOutput("ex_b", bus.ex_b, eb);
            end
            if (bus.id_flush) begin
                busy = 1'b0;
                expQ.delete();
            end else if (expValid && bus.ex_ready) begin
                busy = 1'b0;
                void'(expQ.pop_front());
            end
            if (bus.if_valid && expReady) begin
                expQ.push_back(predict(bus.if_instr, bus.if_pc));
                lastRs = bus.if_instr[25:21];
                lastRt = bus.if_instr[20:16];
                busy   = 1'b1;
                age    = 1;
            end else if (busy) begin
                age++;
            end
        end
    end

    // Drives every input for exactly one clock cycle, starting just after the rising edge.
    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic rdy, input logic we, input logic [4:0] wa,
                                 input logic [31:0] wd, input logic fl);
        @(posedge sys_clk);
        #1;
        bus.if_valid = v;
        bus.if_instr = instr;
        bus.if_pc    = pc;
        bus.ex_ready = rdy;
        bus.wb_we    = we;
        bus.wb_addr  = wa;
        bus.wb_data  = wd;
        bus.id_flush = fl;
    endtask

    task automatic waitValid(input string name);
        int n;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!bus.ex_valid && n < 20);
        if (!bus.ex_valid) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s timeout actual=ex_valid 0 expected=ex_valid 1", name);
        end
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, " if_ready"}, 32'(bus.if_ready), 32'd0);
        checkOutput({name, " ex_valid"}, 32'(bus.ex_valid), 32'd0);
        checkOutput({name, " rf_ra"}, 32'(bus.rf_ra), 32'd0);
        checkOutput({name, " rf_rb"}, 32'(bus.rf_rb), 32'd0);
        checkOutput({name, " ex_pc"}, bus.ex_pc, 32'd0);
        checkOutput({name, " ex_opcode"}, 32'(bus.ex_opcode), 32'd0);
        checkOutput({name, " ex_funct"}, 32'(bus.ex_funct), 32'd0);
        checkOutput({name, " ex_shamt"}, 32'(bus.ex_shamt), 32'd0);
        checkOutput({name, " ex_rd"}, 32'(bus.ex_rd), 32'd0);
        checkOutput({name, " ex_imm"}, bus.ex_imm, 32'd0);
        checkOutput({name, " ex_a"}, bus.ex_a, 32'd0);
        checkOutput({name, " ex_b"}, bus.ex_b, 32'd0);
    endtask

    logic [31:0] rnd;
    logic [31:0] rInstr;
    logic        rValid, rReady, rWe, rFlush;

    initial begin
        checks   = 0;
        failures = 0;
        busy     = 1'b0;
        age      = 0;
        lastRs   = 5'd0;
        lastRt   = 5'd0;
        opList   = '{6'h00, 6'h03, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h04};
        sys_rst_n    = 1'b0;
        bus.if_valid = 1'b0;
        bus.if_instr = '0;
        bus.if_pc    = '0;
        bus.ex_ready = 1'b0;
        bus.wb_we    = 1'b0;
        bus.wb_addr  = '0;
        bus.wb_data  = '0;
        bus.id_flush = 1'b0;
        #2;
        checkAllZero("reset");
        repeat (2) @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b1;

        // Preload every register, including a nonzero r0 the stage must ignore.
        for (int r = 0; r < 32; r++) begin
            rnd = $urandom;
            if (r == 0) rnd = 32'hDEAD0000;
            if (r == 1) rnd = 32'h00002222;
            if (r == 2) rnd = 32'h00003333;
            applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 5'(r), rnd, 1'b0);
        end

        $display("[TB] directed decode cases");
        applyStimulus(1'b1, 32'h00221820, 32'h00000100, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        waitValid("add");
        checkOutput("add ex_a", bus.ex_a, 32'h00002222);
        checkOutput("add ex_b", bus.ex_b, 32'h00003333);
        checkOutput("add ex_rd", 32'(bus.ex_rd), 32'd3);

        applyStimulus(1'b1, 32'h34048001, 32'h00000104, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        waitValid("ori");
        checkOutput("ori ex_a", bus.ex_a, 32'd0);
        checkOutput("ori ex_imm", bus.ex_imm, 32'h00008001);
        checkOutput("ori ex_rd", 32'(bus.ex_rd), 32'd4);

        applyStimulus(1'b1, 32'h20258001, 32'h00000108, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        waitValid("addi");
        checkOutput("addi ex_imm", bus.ex_imm, 32'hFFFF8001);

        applyStimulus(1'b1, 32'h3C061234, 32'h0000010C, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        waitValid("lui");
        checkOutput("lui ex_imm", bus.ex_imm, 32'h12340000);

        $display("[TB] stall then back-to-back accept");
        applyStimulus(1'b1, 32'h00221820, 32'h00000200, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        waitValid("stall");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'h3C061234, 32'h00000204, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
            @(negedge sys_clk);
            checkOutput("stall if_ready", 32'(bus.if_ready), 32'd0);
            checkOutput("stall ex_pc", bus.ex_pc, 32'h00000200);
        end
        applyStimulus(1'b1, 32'h3C061234, 32'h00000204, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge sys_clk);
        checkOutput("b2b ex_valid early", 32'(bus.ex_valid), 32'd0);
        @(negedge sys_clk);
        checkOutput("b2b ex_valid", 32'(bus.ex_valid), 32'd1);
        checkOutput("b2b ex_pc", bus.ex_pc, 32'h00000204);

        $display("[TB] write-back in the read cycle");
        applyStimulus(1'b1, 32'h00221820, 32'h00000300, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 5'd1, 32'h0000AAAA, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        waitValid("bypass");
`ifdef ID_BYPASS_EN
        checkOutput("bypass ex_a", bus.ex_a, 32'h0000AAAA);
`else
        checkOutput("bypass ex_a", bus.ex_a, 32'h00002222);
`endif

        $display("[TB] flush while holding a bundle");
        applyStimulus(1'b1, 32'h00A63820, 32'h00000400, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        waitValid("flush");
        applyStimulus(1'b1, 32'h3C061234, 32'h00000404, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        @(negedge sys_clk);
        checkOutput("flush if_ready", 32'(bus.if_ready), 32'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        @(negedge sys_clk);
        checkOutput("flush ex_valid", 32'(bus.ex_valid), 32'd0);
        checkOutput("flush idle ready", 32'(bus.if_ready), 32'd1);
        checkOutput("flush rf_ra", 32'(bus.rf_ra), 32'd5);

        $display("[TB] reset during the read cycle");
        applyStimulus(1'b1, 32'h00221820, 32'h00000500, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        #2;
        sys_rst_n = 1'b0;
        #1;
        checkAllZero("midreset");
        @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b1;

        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            rnd    = $urandom;
            rInstr = {opList[$urandom_range(0, 9)], rnd[25:0]};
            rFlush = ($urandom_range(0, 24) == 0);
            rValid = ($urandom_range(0, 9) < 7);
            rReady = rFlush ? 1'b0 : ($urandom_range(0, 3) != 0);
            rWe    = ($urandom_range(0, 9) < 4);
            applyStimulus(rValid, rInstr, $urandom, rReady, rWe, 5'($urandom_range(0, 31)),
                          $urandom, rFlush);
        end

        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0);
        end
        @(negedge sys_clk);
        checkOutput("drain ex_valid", 32'(bus.ex_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
